// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - instruction/memory inputs and datapath strobes of the multicycle control unit
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_ready;
    logic [2:0] state;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       jalr;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       instr_done;
    logic       trap;

    modport master (
        input  opcode, funct3, mem_ready,
        output state, pc_write, ir_write, mem_read, mem_write, reg_write,
               mem_to_reg, branch, bne, jump, jalr, alu_src_b, aluop,
               instr_done, trap
    );

    modport slave (
        output opcode, funct3, mem_ready,
        input  state, pc_write, ir_write, mem_read, mem_write, reg_write,
               mem_to_reg, branch, bne, jump, jalr, alu_src_b, aluop,
               instr_done, trap
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait timeout and sticky trap
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT   = 16,
    parameter bit SUPPORT_JUMPS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_unit_if.master  bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] C_R    = 3'd0;
    localparam logic [2:0] C_I    = 3'd1;
    localparam logic [2:0] C_L    = 3'd2;
    localparam logic [2:0] C_S    = 3'd3;
    localparam logic [2:0] C_B    = 3'd4;
    localparam logic [2:0] C_JAL  = 3'd5;
    localparam logic [2:0] C_JALR = 3'd6;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [2:0] r_class;
    logic [2:0] w_class;
    logic       w_legal;
    logic [7:0] r_wait;
    logic       w_timeout;
    logic       w_waiting;

    always_comb begin
        w_class = C_R;
        w_legal = 1'b1;
        case (bus.opcode)
            7'b0110011: w_class = C_R;
            7'b0010011: w_class = C_I;
            7'b0000011: w_class = C_L;
            7'b0100011: w_class = C_S;
            7'b1100011: w_class = C_B;
            7'b1101111: begin
                w_class = C_JAL;
                w_legal = SUPPORT_JUMPS;
            end
            7'b1100111: begin
                w_class = C_JALR;
                w_legal = SUPPORT_JUMPS && (bus.funct3 == 3'b000);
            end
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
    // mem_ready arriving on the timeout cycle still wins over the trap
    assign w_timeout = w_waiting && !bus.mem_ready && (r_wait >= TIMEOUT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready)   w_next = S_DECODE;
                else if (w_timeout)  w_next = S_TRAP;
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (r_class)
                    C_R, C_I, C_JAL, C_JALR: w_next = S_WB;
                    C_L, C_S:                w_next = S_MEM;
                    C_B:                     w_next = S_FETCH;
                    default:                 w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready)   w_next = (r_class == C_L) ? S_WB : S_FETCH;
                else if (w_timeout)  w_next = S_TRAP;
            end
            S_WB:    w_next = S_FETCH;
            default: w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_class <= C_R;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && w_legal)
                r_class <= w_class;
            if (w_next != r_state)
                r_wait <= 8'd0;
            else if (w_waiting && !bus.mem_ready)
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= 8'd0;
        end
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.branch     = 1'b0;
        bus.bne        = 1'b0;
        bus.jump       = 1'b0;
        bus.jalr       = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.aluop      = 2'b00;
        bus.instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_EXEC: begin
                case (r_class)
                    C_R: bus.aluop = 2'b10;
                    C_I: begin
                        bus.aluop     = 2'b10;
                        bus.alu_src_b = 2'b01;
                    end
                    C_L, C_S: bus.alu_src_b = 2'b01;
                    C_B: begin
                        bus.aluop      = 2'b01;
                        bus.branch     = 1'b1;
                        bus.bne        = (bus.funct3 == 3'b001);
                        bus.instr_done = 1'b1;
                    end
                    C_JAL, C_JALR: begin
                        bus.jump     = 1'b1;
                        bus.jalr     = (r_class == C_JALR);
                        bus.pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.mem_read   = (r_class == C_L);
                bus.mem_write  = (r_class == C_S);
                bus.instr_done = (r_class == C_S) && bus.mem_ready;
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (r_class == C_L);
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state = r_state;
    assign bus.trap  = (r_state == S_TRAP);
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed bench for multicycle_control_unit
module tb_multicycle_control_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    multicycle_control_unit_if bus_a ();
    multicycle_control_unit_if bus_b ();

    multicycle_control_unit #(.MEM_TIMEOUT(4), .SUPPORT_JUMPS(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(4), .SUPPORT_JUMPS(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus_a.opcode = 7'b0110011; bus_a.funct3 = 3'b000; bus_a.mem_ready = 1'b0;
        bus_b.opcode = 7'b0110011; bus_b.funct3 = 3'b000; bus_b.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", bus_a.state, 8'd0);
        chk("rst_trap", bus_a.trap, 8'd0);
        rst_n = 1'b1;

        // first cycle after release, memory not ready
        chk("fetch_state", bus_a.state, 8'd0);
        chk("fetch_mem_read", bus_a.mem_read, 8'd1);
        chk("fetch_ir_write_idle", bus_a.ir_write, 8'd0);
        chk("fetch_pc_write_idle", bus_a.pc_write, 8'd0);
        chk("fetch_reg_write", bus_a.reg_write, 8'd0);
        chk("fetch_alu_src_b", bus_a.alu_src_b, 8'd2);

        // R-type, zero-wait
        bus_a.mem_ready = 1'b1;
        #1;
        chk("fetch_ir_write", bus_a.ir_write, 8'd1);
        chk("fetch_pc_write", bus_a.pc_write, 8'd1);
        tick();
        chk("r_decode_state", bus_a.state, 8'd1);
        chk("r_decode_mem_read", bus_a.mem_read, 8'd0);
        tick();
        chk("r_exec_state", bus_a.state, 8'd2);
        chk("r_exec_aluop", bus_a.aluop, 8'd2);
        chk("r_exec_alu_src_b", bus_a.alu_src_b, 8'd0);
        chk("r_exec_reg_write", bus_a.reg_write, 8'd0);
        chk("r_exec_done", bus_a.instr_done, 8'd0);
        tick();
        chk("r_wb_state", bus_a.state, 8'd4);
        chk("r_wb_reg_write", bus_a.reg_write, 8'd1);
        chk("r_wb_mem_to_reg", bus_a.mem_to_reg, 8'd0);
        chk("r_wb_done", bus_a.instr_done, 8'd1);
        tick();
        chk("r_end_state", bus_a.state, 8'd0);
        chk("r_end_done", bus_a.instr_done, 8'd0);
        chk("r_end_reg_write", bus_a.reg_write, 8'd0);

        // load with 3 wait cycles in MEM
        bus_a.opcode = 7'b0000011;
        tick();
        tick();
        chk("l_exec_aluop", bus_a.aluop, 8'd0);
        chk("l_exec_alu_src_b", bus_a.alu_src_b, 8'd1);
        bus_a.mem_ready = 1'b0;
        tick();
        chk("l_mem1_state", bus_a.state, 8'd3);
        chk("l_mem1_mem_read", bus_a.mem_read, 8'd1);
        tick();
        chk("l_mem2_mem_read", bus_a.mem_read, 8'd1);
        tick();
        chk("l_mem3_mem_read", bus_a.mem_read, 8'd1);
        chk("l_mem3_done", bus_a.instr_done, 8'd0);
        tick();
        bus_a.mem_ready = 1'b1;
        #1;
        chk("l_mem4_state", bus_a.state, 8'd3);
        chk("l_mem4_mem_read", bus_a.mem_read, 8'd1);
        chk("l_mem4_done", bus_a.instr_done, 8'd0);
        @(negedge clk);
        chk("l_wb_state", bus_a.state, 8'd4);
        chk("l_wb_mem_to_reg", bus_a.mem_to_reg, 8'd1);
        chk("l_wb_reg_write", bus_a.reg_write, 8'd1);
        chk("l_wb_done", bus_a.instr_done, 8'd1);
        tick();
        chk("l_end_state", bus_a.state, 8'd0);

        // store: ready arrives exactly on the timeout cycle
        bus_a.opcode = 7'b0100011;
        tick();
        tick();
        bus_a.mem_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("s_mem4_state", bus_a.state, 8'd3);
        chk("s_mem4_mem_write", bus_a.mem_write, 8'd1);
        chk("s_mem4_mem_read", bus_a.mem_read, 8'd0);
        tick();
        bus_a.mem_ready = 1'b1;
        #1;
        chk("s_mem5_state", bus_a.state, 8'd3);
        chk("s_mem5_done", bus_a.instr_done, 8'd1);
        @(negedge clk);
        chk("s_end_state", bus_a.state, 8'd0);
        chk("s_end_trap", bus_a.trap, 8'd0);

        // bne: 3 cycles
        bus_a.opcode = 7'b1100011;
        bus_a.funct3 = 3'b001;
        tick();
        tick();
        chk("b_exec_state", bus_a.state, 8'd2);
        chk("b_exec_branch", bus_a.branch, 8'd1);
        chk("b_exec_bne", bus_a.bne, 8'd1);
        chk("b_exec_aluop", bus_a.aluop, 8'd1);
        chk("b_exec_done", bus_a.instr_done, 8'd1);
        tick();
        chk("b_end_state", bus_a.state, 8'd0);

        // jalr
        bus_a.opcode = 7'b1100111;
        bus_a.funct3 = 3'b000;
        tick();
        tick();
        chk("jalr_exec_jump", bus_a.jump, 8'd1);
        chk("jalr_exec_jalr", bus_a.jalr, 8'd1);
        chk("jalr_exec_pc_write", bus_a.pc_write, 8'd1);
        tick();
        chk("jalr_wb_state", bus_a.state, 8'd4);
        chk("jalr_wb_done", bus_a.instr_done, 8'd1);
        tick();

        // jalr with nonzero funct3 is illegal
        bus_a.funct3 = 3'b010;
        tick();
        tick();
        chk("jalr_bad_state", bus_a.state, 8'd5);
        chk("jalr_bad_trap", bus_a.trap, 8'd1);
        chk("jalr_bad_jump", bus_a.jump, 8'd0);

        // reset mid-store MEM
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus_a.opcode = 7'b0100011;
        bus_a.funct3 = 3'b000;
        @(negedge clk);
        tick();
        tick();
        bus_a.mem_ready = 1'b0;
        tick();
        chk("rs_mem_write", bus_a.mem_write, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_mem_write_drop", bus_a.mem_write, 8'd0);
        chk("rs_state", bus_a.state, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // fetch timeout with MEM_TIMEOUT=4
        tick();
        chk("to_c1_state", bus_a.state, 8'd0);
        tick();
        tick();
        tick();
        chk("to_c4_state", bus_a.state, 8'd0);
        chk("to_c4_trap", bus_a.trap, 8'd0);
        tick();
        chk("to_c5_state", bus_a.state, 8'd5);
        chk("to_c5_trap", bus_a.trap, 8'd1);
        bus_a.mem_ready = 1'b1;
        tick();
        tick();
        chk("to_sticky_trap", bus_a.trap, 8'd1);
        chk("to_sticky_mem_read", bus_a.mem_read, 8'd0);
        chk("to_sticky_pc_write", bus_a.pc_write, 8'd0);
        rst_n = 1'b0;
        #1;
        chk("to_rst_trap", bus_a.trap, 8'd0);

        // SUPPORT_JUMPS=0: JAL is illegal
        bus_b.opcode = 7'b1101111;
        bus_b.mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("nj_jal_decode", bus_b.state, 8'd1);
        chk("nj_jal_decode_jump", bus_b.jump, 8'd0);
        tick();
        chk("nj_jal_trap_state", bus_b.state, 8'd5);
        chk("nj_jal_trap", bus_b.trap, 8'd1);
        chk("nj_jal_jump", bus_b.jump, 8'd0);

        // unlisted opcode 0000000
        rst_n = 1'b0;
        bus_b.opcode = 7'b0000000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("nj_zero_decode", bus_b.state, 8'd1);
        tick();
        chk("nj_zero_trap_state", bus_b.state, 8'd5);
        chk("nj_zero_jump", bus_b.jump, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum consecutive cycles spent waiting for mem_ready before trapping, range 1..255.
REQ-002 Parameter SUPPORT_JUMPS, default 1: 1 = JAL/JALR legal; 0 = JAL/JALR decode as illegal.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset; asynchronous, active-low.
REQ-005 Port opcode, input, 7: instr[6:0] from the instruction register.
REQ-006 Port funct3, input, 3: instr[14:12] from the instruction register.
REQ-007 Port mem_ready, input, 1: memory access completes in the current cycle.
REQ-008 Port state, output, 3: current FSM state encoding.
REQ-009 Ports pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, branch, bne, jump, jalr, output, 1 each: datapath strobes.
REQ-010 Port alu_src_b, output, 2: 00 = register, 01 = immediate, 10 = constant 4.
REQ-011 Port aluop, output, 2: 00 = add, 01 = branch compare, 10 = funct-decoded.
REQ-012 Port instr_done, output, 1: one-cycle pulse when an instruction retires.
REQ-013 Port trap, output, 1: sticky error flag.

Function
REQ-014 State encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 go to TRAP on the next edge.
REQ-015 All strobes SHALL be combinational decodes of the state and the registered class; every strobe is 0 unless stated.
REQ-016 FETCH: mem_read=1, alu_src_b=10; on mem_ready=1: ir_write=1, pc_write=1, next state DECODE; else stay in FETCH.
REQ-017 DECODE: register the class from opcode: R=0110011, I=0010011, L=0000011, S=0100011, B=1100011, JAL=1101111, JALR=1100111 (JALR also requires funct3=000).
REQ-018 DECODE: illegal or unlisted opcode -> TRAP; otherwise -> EXEC; the class is held stable until the next DECODE.
REQ-019 EXEC, class R: aluop=10, alu_src_b=00, next WB.
REQ-020 EXEC, class I: aluop=10, alu_src_b=01, next WB.
REQ-021 EXEC, classes L/S: aluop=00, alu_src_b=01, next MEM.
REQ-022 EXEC, class B: aluop=01, alu_src_b=00, branch=1, bne=(funct3==001), next FETCH.
REQ-023 EXEC, JAL/JALR: jump=1, jalr=(class JALR), pc_write=1, next WB.
REQ-024 MEM: L drives mem_read=1; S drives mem_write=1; both hold until mem_ready=1; then L -> WB, S -> FETCH.
REQ-025 WB: reg_write=1, mem_to_reg=(class L), next FETCH.
REQ-026 instr_done SHALL pulse in the last cycle of each instruction: EXEC for B, MEM with mem_ready for S, WB for the other classes.
REQ-027 Wait counter, width 8: cleared on entry to FETCH or MEM and on mem_ready=1; increments each cycle in FETCH/MEM with mem_ready=0.
REQ-028 The counter reaching MEM_TIMEOUT with mem_ready still 0 SHALL force TRAP on the next edge.
REQ-029 mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL complete the access; no trap.
REQ-030 TRAP: trap=1, all strobes 0; TRAP is exited only by reset.
REQ-031 mem_ready SHALL be ignored in DECODE, EXEC and WB.
REQ-032 Latency with zero-wait memory SHALL be: R/I/JAL/JALR 4 cycles, L 5, S 4, B 3.

Reset
REQ-033 rst_n=0 SHALL immediately force state=FETCH, wait counter=0, class=R and trap=0, including mid-instruction.
REQ-034 In the first cycle after reset release the FSM SHALL be in FETCH with mem_read=1 and all other strobes 0.

Verification
REQ-035 R-type 0110011, mem_ready held 1 -> states 0,1,2,4,0; reg_write=1 only in WB; instr_done pulses once.
REQ-036 Load 0000011, mem_ready=0 for 3 MEM cycles then 1 -> mem_read held 4 MEM cycles, then WB with mem_to_reg=1.
REQ-037 B-type, funct3=001 -> EXEC with branch=1, bne=1, aluop=01; next state FETCH; 3 cycles total.
REQ-038 mem_ready held 0 in FETCH with MEM_TIMEOUT=4 -> trap=1 after 5 cycles; stays 1 until rst_n=0.
REQ-039 SUPPORT_JUMPS=0 with opcode 1101111, and separately opcode 0000000 -> DECODE then TRAP; jump is never 1.
REQ-040 rst_n asserted during MEM of a store -> mem_write drops to 0 immediately; state=0 after release.
